// File: rtl/systolic_mm_feeder.sv
// Host-side feeder for a 2x2 systolic array in matrix-multiply mode: loads A/B,
// clears the array, drives skewed operands, drains, and streams back C = A*B.
module systolic_mm_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLR_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  sa_rst,
  output logic                  sa_func_sel,
  output logic [DATA_WIDTH-1:0] sa_data_11,
  output logic [DATA_WIDTH-1:0] sa_data_21,
  output logic [DATA_WIDTH-1:0] sa_tap_11,
  output logic [DATA_WIDTH-1:0] sa_tap_12,
  output logic [DATA_WIDTH-1:0] sa_fir_data_12,
  output logic [DATA_WIDTH-1:0] sa_fir_data_22,
  output logic [DATA_WIDTH-1:0] sa_fir_tap_21,
  output logic [DATA_WIDTH-1:0] sa_fir_tap_22,
  input  logic [DATA_WIDTH-1:0] sa_o_data_11,
  input  logic [DATA_WIDTH-1:0] sa_o_data_12,
  input  logic [DATA_WIDTH-1:0] sa_o_data_21,
  input  logic [DATA_WIDTH-1:0] sa_o_data_22
);
  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  localparam int            CW       = 16;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_CYCLES - 1);

  logic [2:0]                  state;
  logic [2:0]                  in_cnt;
  logic [1:0]                  out_cnt;
  logic [CW-1:0]               cnt;
  // slots: a11 a12 a21 a22 b11 b12 b21 b22
  logic [7:0][DATA_WIDTH-1:0]  ab;
  logic [3:0][DATA_WIDTH-1:0]  c;

  assign sa_func_sel    = 1'b0;
  assign sa_fir_data_12 = '0;
  assign sa_fir_data_22 = '0;
  assign sa_fir_tap_21  = '0;
  assign sa_fir_tap_22  = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      in_cnt     <= '0;
      out_cnt    <= '0;
      cnt        <= '0;
      ab         <= '0;
      c          <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      busy       <= 1'b0;
      sa_rst     <= 1'b1;
      sa_data_11 <= '0;
      sa_data_21 <= '0;
      sa_tap_11  <= '0;
      sa_tap_12  <= '0;
    end else begin
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          sa_rst  <= 1'b0;
          if (s_valid && s_ready) begin
            ab[in_cnt] <= s_data;
            in_cnt     <= in_cnt + 3'd1;  // wraps back to slot 0 after b22
            if (in_cnt == 3'd7) begin
              state   <= CLEAR;
              s_ready <= 1'b0;
              busy    <= 1'b1;
              sa_rst  <= 1'b1;
              cnt     <= '0;
            end
          end
        end
        CLEAR: begin
          cnt <= cnt + CW'(1);
          if (cnt == CLR_LAST) begin
            state      <= FEED;
            cnt        <= '0;
            sa_rst     <= 1'b0;
            sa_data_11 <= ab[0];
            sa_tap_11  <= ab[4];
          end
        end
        FEED: begin
          // row 2 of A and column 2 of B enter one cycle behind row/column 1
          cnt        <= cnt + CW'(1);
          sa_data_11 <= '0;
          sa_data_21 <= '0;
          sa_tap_11  <= '0;
          sa_tap_12  <= '0;
          if (cnt == '0) begin
            sa_data_11 <= ab[1];
            sa_tap_11  <= ab[6];
            sa_data_21 <= ab[2];
            sa_tap_12  <= ab[5];
          end else if (cnt == CW'(1)) begin
            sa_data_21 <= ab[3];
            sa_tap_12  <= ab[7];
          end else begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
          if (cnt == DRN_LAST) begin
            c       <= {sa_o_data_22, sa_o_data_21, sa_o_data_12, sa_o_data_11};
            state   <= OUT;
            cnt     <= '0;
            out_cnt <= '0;
          end
        end
        OUT: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= c[0];
            m_last  <= 1'b0;
          end else if (m_ready) begin
            if (out_cnt == 2'd3) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              out_cnt <= '0;
              busy    <= 1'b0;
              s_ready <= 1'b1;
              state   <= LOAD;
            end else begin
              out_cnt <= out_cnt + 2'd1;
              m_data  <= c[out_cnt + 2'd1];
              m_last  <= (out_cnt == 2'd2);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_mm_feeder.sv
// Bench for systolic_mm_feeder: a behavioural 2x2 array model closes the loop,
// and results are compared against plain matrix products of random operands.
module tb_systolic_mm_feeder;
  localparam int DW  = 32;
  localparam int CLR = 2;
  localparam int DRN = 4;
  localparam int LAT = CLR + 3 + DRN + 1;

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, m_valid, m_ready, m_last, busy, sa_rst, sa_func_sel;
  logic [DW-1:0] s_data, m_data;
  logic [DW-1:0] sa_data_11, sa_data_21, sa_tap_11, sa_tap_12;
  logic [DW-1:0] sa_fir_data_12, sa_fir_data_22, sa_fir_tap_21, sa_fir_tap_22;
  logic [DW-1:0] sa_o_data_11, sa_o_data_12, sa_o_data_21, sa_o_data_22;

  int errors = 0;
  int checks = 0;
  int fir_bad = 0;

  always #5 clk = ~clk;

  systolic_mm_feeder #(.DATA_WIDTH(DW), .CLR_CYCLES(CLR), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .sa_rst(sa_rst), .sa_func_sel(sa_func_sel),
    .sa_data_11(sa_data_11), .sa_data_21(sa_data_21),
    .sa_tap_11(sa_tap_11), .sa_tap_12(sa_tap_12),
    .sa_fir_data_12(sa_fir_data_12), .sa_fir_data_22(sa_fir_data_22),
    .sa_fir_tap_21(sa_fir_tap_21), .sa_fir_tap_22(sa_fir_tap_22),
    .sa_o_data_11(sa_o_data_11), .sa_o_data_12(sa_o_data_12),
    .sa_o_data_21(sa_o_data_21), .sa_o_data_22(sa_o_data_22)
  );

  // output-stationary 2x2 array: A flows right, B flows down, one register per hop
  logic [DW-1:0] acc11, acc12, acc21, acc22, d11r, d21r, t11r, t12r;
  always @(posedge clk) begin
    if (sa_rst) begin
      acc11 <= '0; acc12 <= '0; acc21 <= '0; acc22 <= '0;
      d11r  <= '0; d21r  <= '0; t11r  <= '0; t12r  <= '0;
    end else begin
      acc11 <= acc11 + sa_data_11 * sa_tap_11;
      acc12 <= acc12 + d11r * sa_tap_12;
      acc21 <= acc21 + sa_data_21 * t11r;
      acc22 <= acc22 + d21r * t12r;
      d11r  <= sa_data_11;
      d21r  <= sa_data_21;
      t11r  <= sa_tap_11;
      t12r  <= sa_tap_12;
    end
  end
  assign sa_o_data_11 = acc11;
  assign sa_o_data_12 = acc12;
  assign sa_o_data_21 = acc21;
  assign sa_o_data_22 = acc22;

  always @(negedge clk)
    if (sa_func_sel !== 1'b0 ||
        {sa_fir_data_12, sa_fir_data_22, sa_fir_tap_21, sa_fir_tap_22} !== '0) fir_bad++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] word, input int gap);
    int   t;
    logic hs;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0; s_data = $urandom; @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = word; t = 0;
    do begin
      hs = s_ready; @(posedge clk); #1; t++;
    end while (!hs && t < 64);
    s_valid = 1'b0; s_data = $urandom;
    chk("send_handshake", 128'(hs), 128'(1'b1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  // loads w (a11 a12 a21 a22 b11 b12 b21 b22), checks operand schedule,
  // latency and result stream; gap<0 means a random gap before each word
  task automatic run_xfer(input logic [7:0][DW-1:0] w, input int gap, input logic [5:0] pat);
    logic [DW-1:0] cexp[4];
    logic [DW-1:0] got_d[4];
    logic [3:0]    got_l;
    logic [DW-1:0] e11, et11, e21, et12, pd;
    logic          stall;
    int            lat, feed_bad, hold_bad, stall_bad, got, f;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        cexp[i*2+j] = w[i*2] * w[4+j] + w[i*2+1] * w[6+j];
    for (int k = 0; k < 8; k++) send_word(w[k], (gap < 0) ? int'($urandom_range(2)) : gap);

    lat = -1; feed_bad = 0; hold_bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (m_valid) begin lat = n; break; end
      // skew rule: row i of A and column j of B enter i (resp. j) cycles late
      f = n - CLR;
      e11 = '0; et11 = '0; e21 = '0; et12 = '0;
      if (f >= 0 && f < 2) begin e11 = w[f]; et11 = w[4 + 2*f]; end
      if (f >= 1 && f < 3) begin e21 = w[2 + f - 1]; et12 = w[5 + 2*(f-1)]; end
      if ({sa_data_11, sa_tap_11, sa_data_21, sa_tap_12} !== {e11, et11, e21, et12}) feed_bad++;
      if (sa_rst !== (n < CLR)) feed_bad++;
      if (s_ready !== 1'b0 || busy !== 1'b1) hold_bad++;
      @(posedge clk); #1;
    end
    chk("latency", 128'(lat), 128'(LAT));
    chk("operand_schedule", 128'(feed_bad), 128'(0));

    got = 0; stall = 1'b0; pd = '0; got_l = '0;
    for (int k = 0; k < 4; k++) got_d[k] = '0;
    for (int t = 0; t < 40 && got < 4; t++) begin
      if (stall && (!m_valid || m_data !== pd)) stall_bad++;
      if (s_ready !== 1'b0 || busy !== 1'b1) hold_bad++;
      m_ready = pat[t % 6];
      if (m_valid && m_ready) begin
        got_d[got] = m_data; got_l[got] = m_last; got++;
      end
      stall = m_valid && !m_ready; pd = m_data;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    chk("handshake_count", 128'(got), 128'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("c_word%0d", k), 128'(got_d[k]), 128'(cexp[k]));
    chk("m_last_pattern", 128'(got_l), 128'(4'b1000));
    chk("stall_hold", 128'(stall_bad), 128'(0));
    chk("busy_no_accept", 128'(hold_bad), 128'(0));
    chk("post_idle", 128'({m_valid, s_ready, busy}), 128'(3'b010));
  endtask

  initial begin
    logic [7:0][DW-1:0] w;
    int stall_init;
    stall_init = 0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 128'({s_ready, m_valid, m_last, busy, sa_rst}), 128'(5'b00001));
    chk("reset_mdata", 128'(m_data), 128'(0));
    chk("reset_ops", {sa_data_11, sa_tap_11, sa_data_21, sa_tap_12}, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 128'({s_ready, busy, sa_rst}), 128'(3'b100));

    // 1..8 reference pair, gapless then with a stalling consumer
    for (int k = 0; k < 8; k++) w[k] = DW'(k + 1);
    run_xfer(w, 0, 6'b111111);
    run_xfer(w, 0, 6'b101001);

    // gapped input followed immediately by a second gapless pair
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    run_xfer(w, 1, 6'b111111);
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    run_xfer(w, 0, 6'b111111);

    // abort during FEED f=1
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    for (int k = 0; k < 8; k++) send_word(w[k], 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("at_feed_f1", {sa_data_11, sa_tap_11, sa_data_21, sa_tap_12}, {w[1], w[6], w[2], w[5]});
    pulse_reset();
    chk("midrst_ctrl", 128'({s_ready, m_valid, m_last, busy, sa_rst}), 128'(5'b00001));
    chk("midrst_ops", {sa_data_11, sa_tap_11, sa_data_21, sa_tap_12}, 128'(0));
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    run_xfer(w, 0, 6'b111111);

    // abort partway through a load; next load must restart at slot 0
    for (int k = 0; k < 3; k++) send_word($urandom, 0);
    pulse_reset();
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    run_xfer(w, 0, 6'b111111);

    // all-ones A times identity: wrapped sums pass through untouched
    for (int k = 0; k < 4; k++) w[k] = '1;
    w[4] = DW'(1); w[5] = '0; w[6] = '0; w[7] = DW'(1);
    run_xfer(w, 0, 6'b111111);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) w[k] = $urandom;
      run_xfer(w, -1, 6'($urandom) | 6'b000001);
    end

    chk("fir_and_func_zero", 128'(fir_bad), 128'(stall_init));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_mm_feeder.md
Name: systolic_mm_feeder

Overview:
- Host-side controller for the 2x2 SYSTOLIC array in matrix-multiply mode (func_sel=0).
- Accepts A and B (2x2 each) as an 8-word valid/ready stream and clears the array accumulators.
- Drives the row/column-skewed operand sequence into the array, waits for results to settle, captures o_data_11..22, and returns C=A*B as a 4-word valid/ready stream.
- Sits between the host stream fabric and the SYSTOLIC instance; it is the producer end of the array's operand interface.

Parameters:
DATA_WIDTH, 32, width of every operand/result word
CLR_CYCLES, 2, cycles sa_rst is held high before feeding (>=1)
DRAIN_CYCLES, 4, zero-operand cycles after last operand before capture (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  DATA_WIDTH  order a11,a12,a21,a22,b11,b12,b21,b22
m_valid  out  1  result word valid
m_ready  in  1  result consumer ready
m_data  out  DATA_WIDTH  order c11,c12,c21,c22
m_last  out  1  high with c22
busy  out  1  high in every state except LOAD
sa_rst  out  1  to array rst (accumulator clear)
sa_func_sel  out  1  constant 0
sa_data_11, sa_data_21  out  DATA_WIDTH each  A row operands
sa_tap_11, sa_tap_12  out  DATA_WIDTH each  B column operands
sa_fir_data_12, sa_fir_data_22, sa_fir_tap_21, sa_fir_tap_22  out  DATA_WIDTH each  constant 0
sa_o_data_11, sa_o_data_12, sa_o_data_21, sa_o_data_22  in  DATA_WIDTH each  array results

Behaviour:
- All outputs registered. On rst: state=LOAD, word counters=0, A/B/C regs=0, all sa_* operands=0, m_valid=0, m_last=0, busy=0, s_ready=0 during the rst cycle. sa_rst=1 while rst high.
- FSM states: LOAD -> CLEAR -> FEED -> DRAIN -> OUT -> LOAD.
- LOAD: s_ready=1. Each handshake stores s_data into slot in_cnt (0..7), in_cnt++. s_valid gaps allowed. On the 8th handshake: in_cnt=0, next state CLEAR.
- CLEAR: sa_rst=1 and operands=0 for exactly CLR_CYCLES cycles.
- FEED: exactly 3 cycles f=0,1,2; sa_rst=0. Unlisted operands are 0.
  - f=0: data_11=a11, tap_11=b11
  - f=1: data_11=a12, tap_11=b21, data_21=a21, tap_12=b12
  - f=2: data_21=a22, tap_12=b22
- DRAIN: DRAIN_CYCLES cycles, all operands 0. At the clock edge ending the last DRAIN cycle, capture sa_o_data_11/12/21/22 into c11/c12/c21/c22.
- OUT: m_valid=1, m_data=C[out_cnt], m_last=(out_cnt==3). m_data is stable while m_valid&!m_ready. Each handshake increments out_cnt. Handshake at out_cnt==3 -> m_valid=0, state LOAD.
- Latency: m_valid rises exactly CLR_CYCLES+3+DRAIN_CYCLES+1 cycles after the 8th input handshake edge (10 with defaults).
- Back-to-back: s_ready returns high in the cycle after the c22 handshake. No input is accepted while busy.
- Arithmetic: the block does no math. Results pass through unmodified at DATA_WIDTH; overflow behaviour belongs to the array.
- Reset mid-operation (any state): abort immediately. Partial input and pending results are discarded, all outputs return to reset values, and the next transfer starts at slot 0.
- m_ready may be high outside OUT; it has no effect.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], m_ready=1, with the real SYSTOLIC instance -> m_data 19,22,43,50; m_last only on 50; m_valid rises 10 cycles after the 8th handshake.
- Same input, monitor sa_* per cycle -> sa_rst high 2 cycles; FEED cycles show (1,5,-,-), (2,7,3,6), (-,-,4,8); all FIR ports and func_sel are 0 throughout.
- m_ready toggled 1-0-0-1-0-1 during OUT -> each word held stable while stalled; exactly 4 handshakes, no duplicates or skips.
- s_valid driven with 1-cycle gaps between words, then a second matrix pair sent immediately after -> results identical to the gapless case; s_ready=0 from the 8th handshake until after c22.
- rst pulsed for 1 cycle at FEED f=1 -> all outputs zero the next cycle; a fresh 8-word load then yields the correct C with no residue from the aborted run.
- A=all 0xFFFFFFFF, B=identity -> C words equal the array's raw sa_o_data values; the feeder passes them through unmodified.
